// File: rtl/nsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nsa_pkg
//  Description : Shared types, defaults and helpers for nor_slice_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package nsa_pkg;

    localparam int c_default_width  = 3;
    localparam int c_default_nreq   = 2;
    localparam int c_default_qdepth = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } nsa_state_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nsa_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nsa_rsp_fifo
//  Description : Synchronous response FIFO with occupancy count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module nsa_rsp_fifo
    import nsa_pkg::*;
#(
    parameter int DW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic [DW-1:0]                       wdata,
    input  logic                                pop,
    output logic [DW-1:0]                       rdata,
    output logic [clog2_min1(DEPTH+1)-1:0]      count
);

    localparam int c_aw = clog2_min1(DEPTH);
    localparam int c_cw = clog2_min1(DEPTH + 1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;
    logic            w_pop;

    function automatic logic [c_aw-1:0] ptr_next(input logic [c_aw-1:0] p);
        return (p == c_aw'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pops of an empty FIFO are ignored so the count can never underflow.
    assign w_pop = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/nor_slice_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nor_slice_arbiter
//  Description : Arbitrates NREQ requesters onto one bit-serial NOR slice and
//                returns id-tagged results through a response FIFO.
//                NSA_FIXED_PRIO_EN selects fixed priority instead of
//                round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module nor_slice_arbiter
    import nsa_pkg::*;
#(
    parameter int WIDTH  = c_default_width,
    parameter int NREQ   = c_default_nreq,
    parameter int QDEPTH = c_default_qdepth,
    parameter int IDW    = clog2_min1(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_y,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    localparam int c_cntw = clog2_min1(WIDTH);
    localparam int c_fcw  = clog2_min1(QDEPTH + 1);

    nsa_state_t          r_state;
    logic [c_cntw-1:0]   r_cnt;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_res;
    logic [IDW-1:0]      r_id;
`ifdef NSA_FIXED_PRIO_EN
`else
    logic [IDW-1:0]      r_ptr;
`endif

    logic                w_gnt_found;
    logic [IDW-1:0]      w_gnt;
    logic                w_space;
    logic                w_accept;
    logic                w_last;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_valid;
    logic [WIDTH-1:0]    w_res_next;
    logic [WIDTH+IDW-1:0] w_head;
    logic [c_fcw-1:0]    w_count;

    // Walk from the highest offset down so the lowest offset wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
`ifdef NSA_FIXED_PRIO_EN
            if (req_valid[i]) begin
                w_gnt_found = 1'b1;
                w_gnt       = IDW'(i);
            end
`else
            if (req_valid[(int'(r_ptr) + i) % NREQ]) begin
                w_gnt_found = 1'b1;
                w_gnt       = IDW'((int'(r_ptr) + i) % NREQ);
            end
`endif
        end
    end

    assign w_space  = (w_count < c_fcw'(QDEPTH));
    assign w_accept = rst_n && (r_state == ST_IDLE) && w_space && w_gnt_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // Result including the bit computed this cycle, so the final push is complete.
    always_comb begin
        w_res_next        = r_res;
        w_res_next[r_cnt] = ~(r_a[r_cnt] | r_b[r_cnt]);
    end

    assign w_last = (r_cnt == c_cntw'(WIDTH - 1));
    assign w_push = (r_state == ST_CALC) && w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_id    <= '0;
`ifdef NSA_FIXED_PRIO_EN
`else
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[int'(w_gnt)*WIDTH +: WIDTH];
                        r_b     <= req_b[int'(w_gnt)*WIDTH +: WIDTH];
                        r_id    <= w_gnt;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CALC;
`ifdef NSA_FIXED_PRIO_EN
`else
                        r_ptr   <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
`endif
                    end
                end
                ST_CALC: begin
                    r_res <= w_res_next;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_fifo_valid = (w_count != '0);
    assign w_pop        = w_fifo_valid && rsp_ready;

    nsa_rsp_fifo #(
        .DW    (WIDTH + IDW),
        .DEPTH (QDEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata ({w_res_next, r_id}),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_count)
    );

    // Outputs are forced to zero while in reset or when no head exists.
    assign rsp_valid = rst_n && w_fifo_valid;
    assign rsp_y     = rsp_valid ? w_head[IDW +: WIDTH] : '0;
    assign rsp_id    = rsp_valid ? w_head[IDW-1:0]      : '0;
    assign busy      = rst_n && (r_state == ST_CALC);

endmodule
`default_nettype wire

// File: tb/tb_nor_slice_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nor_slice_arbiter
//  Description : Directed self-checking bench for nor_slice_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nor_slice_arbiter;

    localparam int WIDTH  = 3;
    localparam int NREQ   = 2;
    localparam int QDEPTH = 2;
    localparam int IDW    = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] rr_ready_exp [4];
    logic [31:0] rr_id_exp   [4];

    always #5 clk = ~clk;

    nor_slice_arbiter #(
        .WIDTH  (WIDTH),
        .NREQ   (NREQ),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef NSA_FIXED_PRIO_EN
        rr_ready_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
        rr_id_exp    = '{32'd0, 32'd0, 32'd0, 32'd0};
`else
        rr_ready_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_id_exp    = '{32'd0, 32'd1, 32'd0, 32'd1};
`endif
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset with requests pending
        tick(); tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_y", 32'(rsp_y), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        tick(); tick(); tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check("idle_ready", 32'(req_ready), 32'h0);

        // Single request; operands changed right after the handshake
        req_a[2:0] = 3'b100;
        req_b[2:0] = 3'b001;
        req_valid  = 2'b01;
        rsp_ready  = 1'b1;
        #1;
        check("s1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid  = 2'b00;
        req_a[2:0] = 3'b111;
        req_b[2:0] = 3'b111;
        check("s1_busy_e0", 32'(busy), 32'h1);
        tick(); tick();
        check("s1_nvalid_e2", 32'(rsp_valid), 32'h0);
        check("s1_busy_e2", 32'(busy), 32'h1);
        tick();
        check("s1_valid", 32'(rsp_valid), 32'h1);
        check("s1_y", 32'(rsp_y), 32'h2);
        check("s1_id", 32'(rsp_id), 32'h0);
        check("s1_busy_e3", 32'(busy), 32'h0);
        tick();
        check("s1_popped", 32'(rsp_valid), 32'h0);

        // All-zero operands give all ones
        req_a[2:0] = 3'b000;
        req_b[2:0] = 3'b000;
        req_valid  = 2'b01;
        tick();
        req_valid = 2'b00;
        tick(); tick(); tick();
        check("s2_valid", 32'(rsp_valid), 32'h1);
        check("s2_y", 32'(rsp_y), 32'h7);
        tick();

        // Reset to put the round-robin pointer back at 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Both requesters held valid
        req_a     = {3'b101, 3'b101};
        req_b     = {3'b010, 3'b010};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(rr_ready_exp[k]));
            tick(); tick(); tick(); tick();
            check("rr_valid", 32'(rsp_valid), 32'h1);
            check("rr_y", 32'(rsp_y), 32'h0);
            check("rr_id", 32'(rsp_id), rr_id_exp[k]);
        end
        req_valid = 2'b00;
        tick();
        check("rr_drain", 32'(rsp_valid), 32'h0);

        // Backpressure: fill the FIFO
        rsp_ready = 1'b0;
        req_a     = {3'b010, 3'b000};
        req_b     = {3'b000, 3'b001};
        req_valid = 2'b01;
        #1;
        check("bp_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        tick(); tick(); tick();
        check("bp_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b11;
        tick(); tick(); tick();
        check("bp_full_ready", 32'(req_ready), 32'h0);
        check("bp_full_busy", 32'(busy), 32'h0);
        check("bp_head_y", 32'(rsp_y), 32'h6);
        check("bp_head_id", 32'(rsp_id), 32'h0);
        tick(); tick();
        check("bp_hold_ready", 32'(req_ready), 32'h0);
        check("bp_hold_y", 32'(rsp_y), 32'h6);
        check("bp_hold_busy", 32'(busy), 32'h0);
        req_a[2:0] = 3'b111;
        req_b[2:0] = 3'b111;
        rsp_ready  = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_second_y", 32'(rsp_y), 32'h5);
        check("bp_second_id", 32'(rsp_id), 32'h1);
        check("bp_reopen_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick(); tick();
        check("pp_head_held", 32'(rsp_y), 32'h5);

        // Pop and push on the same edge
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("pp_valid", 32'(rsp_valid), 32'h1);
        check("pp_y", 32'(rsp_y), 32'h0);
        check("pp_id", 32'(rsp_id), 32'h0);
        tick();
        check("pp_still_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("pp_empty", 32'(rsp_valid), 32'h0);

        // Reset in the middle of a calculation
        req_a[2:0] = 3'b000;
        req_b[2:0] = 3'b000;
        req_valid  = 2'b01;
        #1;
        check("mr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_rst_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("mr_no_rsp", 32'(rsp_valid), 32'h0);
        rsp_ready = 1'b1;
        req_a     = {3'b000, 3'b001};
        req_b     = {3'b000, 3'b000};
        req_valid = 2'b11;
        #1;
        check("mr_ptr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick(); tick(); tick();
        check("mr_valid", 32'(rsp_valid), 32'h1);
        check("mr_y", 32'(rsp_y), 32'h6);
        check("mr_id", 32'(rsp_id), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
